ttc_timer_counter_param13: RTL

Parametrised successor to the lite timer-counter channel: a single timer with configurable counter width, configurable number of match comparators, a programmable linear prescaler, up/down counting, interval/overflow modes and one-shot operation. It sits behind the TTC APB register decoder, which presents decoded write strobes and addresses. It produces a sticky interrupt status vector and one masked interrupt line toward the TTC interrupt combiner.

---
 rtl/ttc_timer_counter_param13.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ttc_timer_counter_param13.sv
// ttc_timer_counter_param13 - parametrised TTC timer/counter channel.
// Width-configurable counter with N_MATCH comparators, linear prescaler,
// interval/overflow modes, one-shot and restart.
// Optional feature: define TTC_DOWNCOUNT_EN to implement down counting
// (cntr_ctrl bit2); without it the bit reads 0 and the counter is up-only.
module ttc_timer_counter_param13 #(
  parameter int CNT_W   = 16,
  parameter int N_MATCH = 3,
  parameter int PRE_W   = 8
) (
  input  logic                       pclk13,
  input  logic                       p_reset13,
  input  logic                       reg_wr13,
  input  logic [3:0]                 reg_addr13,
  input  logic [CNT_W-1:0]           pwdata13,
  input  logic                       clear_interrupt13,
  output logic [PRE_W:0]             clk_ctrl_reg13,
  output logic [5:0]                 cntr_ctrl_reg13,
  output logic [CNT_W-1:0]           counter_val13,
  output logic [CNT_W-1:0]           interval_reg13,
  output logic [N_MATCH*CNT_W-1:0]   match_reg13,
  output logic [N_MATCH+1:0]         interrupt_en_reg13,
  output logic [N_MATCH+1:0]         interrupt_reg13,
  output logic                       interrupt13
);
  localparam int NI = N_MATCH + 2;

  logic [PRE_W:0]     r_clk;
  logic [5:0]         r_ctrl;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_interval;
  logic [NI-1:0]      r_en;
  logic [NI-1:0]      r_int;
  logic               r_irq;
  logic [PRE_W-1:0]   r_pre;

  logic [PRE_W:0]     w_clk_wd;
  logic [NI-1:0]      w_en_wd;
  logic               w_pre_hit;
  logic               w_tick;
  logic               w_restart;
  logic               w_wr_dec;
  logic [CNT_W-1:0]   w_restart_val;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_iv;
  logic               w_ov;
  logic [N_MATCH-1:0] w_hit;
  logic [NI-1:0]      w_evt;

  // Write data zero-extended/truncated to the clk_ctrl and enable fields
  for (genvar gi = 0; gi <= PRE_W; gi++) begin : g_clkwd
    if (gi < CNT_W) begin : g_b
      assign w_clk_wd[gi] = pwdata13[gi];
    end else begin : g_z
      assign w_clk_wd[gi] = 1'b0;
    end
  end
  for (genvar gi = 0; gi < NI; gi++) begin : g_enwd
    if (gi < CNT_W) begin : g_b
      assign w_en_wd[gi] = pwdata13[gi];
    end else begin : g_z
      assign w_en_wd[gi] = 1'b0;
    end
  end

  assign w_pre_hit = (r_pre == r_clk[PRE_W:1]);
  assign w_tick    = !r_ctrl[0] && (!r_clk[0] || w_pre_hit);
  assign w_restart = reg_wr13 && (reg_addr13 == 4'd1) && pwdata13[4];

`ifdef TTC_DOWNCOUNT_EN
  assign w_wr_dec      = pwdata13[2];
  assign w_restart_val = !pwdata13[2] ? '0 : (pwdata13[1] ? r_interval : '1);
`else
  assign w_wr_dec      = 1'b0;
  assign w_restart_val = '0;
`endif

  // Next count and wrap events for one tick, from the current mode bits
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_iv      = 1'b0;
    w_ov      = 1'b0;
`ifdef TTC_DOWNCOUNT_EN
    if (r_ctrl[2]) begin
      if (r_cnt == '0) begin
        if (r_ctrl[1]) begin
          w_cnt_nxt = r_interval;
          w_iv      = 1'b1;
        end else begin
          w_cnt_nxt = '1;
          w_ov      = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else
`endif
    begin
      if (r_ctrl[1] && (r_cnt == r_interval)) begin
        w_cnt_nxt = '0;
        w_iv      = 1'b1;
      end else if (r_cnt == '1) begin
        w_cnt_nxt = '0;
        w_ov      = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Match comparators: one register and compare per channel
  for (genvar gk = 0; gk < N_MATCH; gk++) begin : g_match
    logic [CNT_W-1:0] r_m;
    // Match register k write
    always_ff @(posedge pclk13) begin
      if (p_reset13)
        r_m <= '0;
      else if (reg_wr13 && (reg_addr13 == 4'(gk + 3)))
        r_m <= pwdata13;
    end
    assign w_hit[gk] = r_ctrl[3] && (w_cnt_nxt == r_m);
    assign match_reg13[gk*CNT_W +: CNT_W] = r_m;
  end

  // A restart in the same cycle swallows the tick and all its events
  assign w_evt = (w_tick && !w_restart) ? {w_ov, w_hit, w_iv} : '0;

  // Counter, prescaler, control/status registers and interrupt line
  always_ff @(posedge pclk13) begin
    if (p_reset13) begin
      r_clk      <= '0;
      r_ctrl     <= 6'h01;
      r_cnt      <= '0;
      r_interval <= '0;
      r_en       <= '0;
      r_int      <= '0;
      r_irq      <= 1'b0;
      r_pre      <= '0;
    end else begin
      if (!r_ctrl[0])
        r_pre <= (r_clk[0] && !w_pre_hit) ? r_pre + PRE_W'(1) : '0;
      if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        if (r_ctrl[5] && (w_iv || w_ov))
          r_ctrl[0] <= 1'b1;
      end
      r_int <= (clear_interrupt13 ? '0 : r_int) | w_evt;
      r_irq <= |(r_int & r_en);
      if (reg_wr13) begin
        case (reg_addr13)
          4'd0:  r_clk <= w_clk_wd;
          4'd1: begin
            r_ctrl <= {pwdata13[5], 1'b0, pwdata13[3], w_wr_dec, pwdata13[1:0]};
            if (pwdata13[4]) begin
              r_cnt <= w_restart_val;
              r_pre <= '0;
            end
          end
          4'd2:  r_interval <= pwdata13;
          4'd14: r_en <= w_en_wd;
          default: ;
        endcase
      end
    end
  end

  assign clk_ctrl_reg13     = r_clk;
  assign cntr_ctrl_reg13    = r_ctrl;
  assign counter_val13      = r_cnt;
  assign interval_reg13     = r_interval;
  assign interrupt_en_reg13 = r_en;
  assign interrupt_reg13    = r_int;
  assign interrupt13        = r_irq;
endmodule
